// File: rtl/contador_m_prog.sv
// contador_m_prog -- programmable modulo counter with prescaler.
//
// Counts 0..limite up or down. Wraps (with a one-cycle estouro pulse) or
// saturates at the ends of the range. A built-in prescaler turns every
// PRESC enabled cycles into one count step. The control FSM drives
// zera_s/carrega/conta and reads fim/meio/estouro.
//
// Ports:
//   clock        rising-edge clock
//   zera_as_n    asynchronous reset, active low (Q, prescaler, estouro -> 0)
//   zera_s       synchronous clear of Q and prescaler (highest priority)
//   carrega      synchronous load of min(valor_carga, limite)
//   valor_carga  load value
//   conta        count enable (advances the prescaler)
//   desce        0 = count up, 1 = count down
//   modo_sat     0 = wrap at range ends, 1 = saturate at range ends
//   limite       terminal value, range is 0..limite (may change any cycle)
//   Q            registered count
//   fim          combinational terminal flag (Q==limite up, Q==0 down)
//   meio         combinational flag Q == limite>>1
//   estouro      registered one-cycle pulse after a wrap
module contador_m_prog #(
  parameter int N     = 8,
  parameter int PRESC = 1,
  parameter int PW    = (PRESC > 1) ? $clog2(PRESC) : 1
) (
  input  logic         clock,
  input  logic         zera_as_n,
  input  logic         zera_s,
  input  logic         carrega,
  input  logic [N-1:0] valor_carga,
  input  logic         conta,
  input  logic         desce,
  input  logic         modo_sat,
  input  logic [N-1:0] limite,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         estouro
);

  logic [PW-1:0] presc;
  logic          presc_end;
  logic [N-1:0]  step_q;
  logic          step_wrap;
  logic [N-1:0]  carga_q;

  assign presc_end = (presc == PW'(PRESC - 1));
  assign carga_q   = (valor_carga > limite) ? limite : valor_carga;

  // Next value of Q if this cycle is a step. Always evaluated against the
  // current limite, so a shrinking limite pulls Q back into range on the
  // next step without any extra state.
  always_comb begin
    step_q    = Q;
    step_wrap = 1'b0;
    if (!desce) begin
      if (Q < limite) begin
        step_q = Q + N'(1);
      end else if (modo_sat) begin
        // Q == limite holds; Q > limite clamps. Both reduce to limite.
        step_q = limite;
      end else begin
        step_q    = '0;
        step_wrap = 1'b1;
      end
    end else begin
      // Out-of-range clamp takes precedence over the decrement/wrap rules
      // and never produces estouro.
      if (Q > limite) begin
        step_q = limite;
      end else if (Q != '0) begin
        step_q = Q - N'(1);
      end else if (modo_sat) begin
        step_q = Q;
      end else begin
        step_q    = limite;
        step_wrap = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge zera_as_n) begin
    if (!zera_as_n) begin
      Q       <= '0;
      presc   <= '0;
      estouro <= 1'b0;
    end else if (zera_s) begin
      Q       <= '0;
      presc   <= '0;
      estouro <= 1'b0;
    end else if (carrega) begin
      Q       <= carga_q;
      presc   <= '0;
      estouro <= 1'b0;
    end else if (conta) begin
      if (presc_end) begin
        presc   <= '0;
        Q       <= step_q;
        estouro <= step_wrap;
      end else begin
        presc   <= presc + PW'(1);
        estouro <= 1'b0;
      end
    end else begin
      // Idle: prescaler phase is kept so a paused count resumes mid-period.
      estouro <= 1'b0;
    end
  end

  assign fim  = desce ? (Q == '0) : (Q == limite);
  assign meio = (Q == (limite >> 1));

endmodule

// File: tb/tb_contador_m_prog.sv
// Directed-vector bench for contador_m_prog. Three instances (PRESC = 1, 3
// and 4, N = 4) share one set of input drivers; each scenario checks the
// instance whose prescaling it exercises.
module tb_contador_m_prog;

  logic       clock = 1'b0;
  logic       zera_as_n, zera_s, carrega, conta, desce, modo_sat;
  logic [3:0] valor_carga, limite;

  logic [3:0] q1, q3, q4;
  logic       fim1, meio1, est1, fim3, meio3, est3, fim4, meio4, est4;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  contador_m_prog #(.N(4), .PRESC(1)) u1 (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .carrega(carrega),
    .valor_carga(valor_carga), .conta(conta), .desce(desce), .modo_sat(modo_sat),
    .limite(limite), .Q(q1), .fim(fim1), .meio(meio1), .estouro(est1));

  contador_m_prog #(.N(4), .PRESC(3)) u3 (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .carrega(carrega),
    .valor_carga(valor_carga), .conta(conta), .desce(desce), .modo_sat(modo_sat),
    .limite(limite), .Q(q3), .fim(fim3), .meio(meio3), .estouro(est3));

  contador_m_prog #(.N(4), .PRESC(4)) u4 (
    .clock(clock), .zera_as_n(zera_as_n), .zera_s(zera_s), .carrega(carrega),
    .valor_carga(valor_carga), .conta(conta), .desce(desce), .modo_sat(modo_sat),
    .limite(limite), .Q(q4), .fim(fim4), .meio(meio4), .estouro(est4));

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_sync();
    zera_s = 1'b1; carrega = 1'b0; conta = 1'b0;
    tick();
    zera_s = 1'b0;
  endtask

  task automatic test_reset();
    zera_as_n = 1'b0; zera_s = 1'b0; carrega = 1'b0; conta = 1'b1;
    desce = 1'b0; modo_sat = 1'b0; valor_carga = 4'd0; limite = 4'd9;
    #3;
    vectors++; if (q1 !== 4'd0 || est1 !== 1'b0) begin miscompares++;
      $display("FAIL reset_async q1=%0d est1=%0b expected 0/0", q1, est1); end
    tick(); tick();
    vectors++; if (q1 !== 4'd0 || q3 !== 4'd0 || q4 !== 4'd0) begin miscompares++;
      $display("FAIL reset_held q1=%0d q3=%0d q4=%0d expected 0", q1, q3, q4); end
    vectors++; if (fim1 !== 1'b0 || meio1 !== 1'b0) begin miscompares++;
      $display("FAIL reset_flags fim=%0b meio=%0b expected 0/0", fim1, meio1); end
    zera_as_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    logic [3:0] eq;
    limite = 4'd9; desce = 1'b0; modo_sat = 1'b0; conta = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      eq = 4'(k % 10);
      vectors++; if (q1 !== eq || est1 !== (k == 10)) begin miscompares++;
        $display("FAIL wrap_up step %0d q=%0d est=%0b expected %0d/%0b", k, q1, est1, eq, (k == 10)); end
      vectors++; if (fim1 !== (eq == 4'd9) || meio1 !== (eq == 4'd4)) begin miscompares++;
        $display("FAIL wrap_up_flags step %0d fim=%0b meio=%0b expected %0b/%0b", k, fim1, meio1, (eq == 4'd9), (eq == 4'd4)); end
    end
    conta = 1'b0;
  endtask

  task automatic test_prescale();
    // conta pattern per edge and expected q3 after that edge
    logic       cp [11] = '{1,1,1,1,1,1,1,0,0,1,1};
    logic [3:0] eq [11] = '{0,0,1,1,1,2,2,2,2,2,3};
    limite = 4'd5; desce = 1'b0; modo_sat = 1'b0;
    clear_sync();
    for (int k = 0; k < 11; k++) begin
      conta = cp[k];
      tick();
      vectors++; if (q3 !== eq[k] || est3 !== 1'b0) begin miscompares++;
        $display("FAIL prescale edge %0d q=%0d est=%0b expected %0d/0", k + 1, q3, est3, eq[k]); end
    end
    conta = 1'b0;
  endtask

  task automatic test_down();
    logic [3:0] eq [3] = '{7, 6, 5};
    limite = 4'd7; desce = 1'b1; modo_sat = 1'b0;
    clear_sync();
    vectors++; if (fim1 !== 1'b1) begin miscompares++;
      $display("FAIL down_fim0 fim=%0b expected 1", fim1); end
    conta = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (q1 !== eq[k] || est1 !== (k == 0)) begin miscompares++;
        $display("FAIL down_wrap step %0d q=%0d est=%0b expected %0d/%0b", k, q1, est1, eq[k], (k == 0)); end
    end
    clear_sync();
    modo_sat = 1'b1; conta = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (q1 !== 4'd0 || est1 !== 1'b0 || fim1 !== 1'b1) begin miscompares++;
        $display("FAIL down_sat step %0d q=%0d est=%0b fim=%0b expected 0/0/1", k, q1, est1, fim1); end
    end
    conta = 1'b0; desce = 1'b0; modo_sat = 1'b0;
  endtask

  task automatic test_load();
    limite = 4'd9; desce = 1'b0; modo_sat = 1'b0;
    carrega = 1'b1; valor_carga = 4'd12; conta = 1'b0;
    tick();
    vectors++; if (q1 !== 4'd9 || fim1 !== 1'b1) begin miscompares++;
      $display("FAIL load_clamp q=%0d fim=%0b expected 9/1", q1, fim1); end
    zera_s = 1'b1;
    tick();
    zera_s = 1'b0;
    vectors++; if (q1 !== 4'd0) begin miscompares++;
      $display("FAIL clear_over_load q=%0d expected 0", q1); end
    conta = 1'b1;
    tick();
    vectors++; if (q1 !== 4'd9 || est1 !== 1'b0) begin miscompares++;
      $display("FAIL load_over_count q=%0d est=%0b expected 9/0", q1, est1); end
    valor_carga = 4'd3;
    tick();
    vectors++; if (q1 !== 4'd3) begin miscompares++;
      $display("FAIL load_small q=%0d expected 3", q1); end
    carrega = 1'b0; conta = 1'b0;
  endtask

  // Load Q=8 under limite=9, shrink limite to 5, take one step.
  task automatic test_limit_change();
    logic       dn [4] = '{0, 0, 1, 1};
    logic       st [4] = '{0, 1, 0, 1};
    logic [3:0] eq [4] = '{0, 5, 5, 5};
    logic       ee [4] = '{1, 0, 0, 0};
    for (int k = 0; k < 4; k++) begin
      limite = 4'd9; valor_carga = 4'd8; carrega = 1'b1; conta = 1'b0;
      desce = dn[k]; modo_sat = st[k];
      tick();
      carrega = 1'b0; limite = 4'd5; conta = 1'b1;
      tick();
      conta = 1'b0;
      vectors++; if (q1 !== eq[k] || est1 !== ee[k]) begin miscompares++;
        $display("FAIL limit_change case %0d q=%0d est=%0b expected %0d/%0b", k, q1, est1, eq[k], ee[k]); end
    end
    desce = 1'b0; modo_sat = 1'b0;
  endtask

  task automatic test_limite_zero();
    limite = 4'd0; desce = 1'b0; modo_sat = 1'b0;
    clear_sync();
    conta = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (q1 !== 4'd0 || est1 !== 1'b1 || fim1 !== 1'b1 || meio1 !== 1'b1) begin miscompares++;
        $display("FAIL lim0_wrap step %0d q=%0d est=%0b fim=%0b meio=%0b expected 0/1/1/1", k, q1, est1, fim1, meio1); end
    end
    modo_sat = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++; if (q1 !== 4'd0 || est1 !== 1'b0) begin miscompares++;
        $display("FAIL lim0_sat step %0d q=%0d est=%0b expected 0/0", k, q1, est1); end
    end
    conta = 1'b0; modo_sat = 1'b0;
  endtask

  task automatic test_async_midcount();
    limite = 4'd9; desce = 1'b0; modo_sat = 1'b0;
    clear_sync();
    conta = 1'b1;
    for (int k = 0; k < 26; k++) tick();
    vectors++; if (q4 !== 4'd6) begin miscompares++;
      $display("FAIL presc4_count q=%0d expected 6", q4); end
    #2 zera_as_n = 1'b0;
    #1;
    vectors++; if (q4 !== 4'd0 || est4 !== 1'b0) begin miscompares++;
      $display("FAIL async_mid q=%0d est=%0b expected 0/0", q4, est4); end
    #1 zera_as_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      vectors++; if (q4 !== ((k == 4) ? 4'd1 : 4'd0)) begin miscompares++;
        $display("FAIL async_resume edge %0d q=%0d expected %0d", k, q4, (k == 4) ? 1 : 0); end
    end
    conta = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap_up();
    test_prescale();
    test_down();
    test_load();
    test_limit_change();
    test_limite_zero();
    test_async_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
